// File: rtl/adc_pkg.sv
// Shared definitions for the ADC scan controller: FSM encoding and converter geometry.
package adc_pkg;

   localparam int ADC_BITS     = 12;
   localparam int ADC_CHANNELS = 8;
   localparam int CH_W         = 3;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      SCAN_INIT = 3'd1,
      ISSUE     = 3'd2,
      WAIT      = 3'd3,
      STORE     = 3'd4,
      NEXT      = 3'd5,
      GAP       = 3'd6
   } scan_state_t;

endpackage

// File: rtl/adc_next_ch.sv
// Priority encoder: lowest set mask bit strictly above i_ptr, or lowest set bit overall
// when i_from_start is high.
module adc_next_ch
   import adc_pkg::*;
(
   input  logic [ADC_CHANNELS-1:0] i_mask,
   input  logic [CH_W-1:0]         i_ptr,
   input  logic                    i_from_start,
   output logic [CH_W-1:0]         o_ch,
   output logic                    o_found
);

   logic [ADC_CHANNELS-1:0] w_keep;
   logic [ADC_CHANNELS-1:0] w_cand;

   assign w_keep = i_from_start ? 8'hFF : (8'hFE << i_ptr);
   assign w_cand = i_mask & w_keep;

   // Descending scan so the lowest candidate is the one left standing.
   always_comb begin
      o_ch    = 3'd0;
      o_found = 1'b0;
      for (int i = ADC_CHANNELS - 1; i >= 0; i--) begin
         o_found = o_found | w_cand[i];
         o_ch    = w_cand[i] ? 3'(i) : o_ch;
      end
   end

endmodule

// File: rtl/adc_scan_ctrl.sv
// Round-robin scan sequencer for the SPI ADC driver: issues conversions, averages
// 2^AVG_LOG2 samples per enabled channel and keeps the averages in a small result file.
module adc_scan_ctrl
   import adc_pkg::*;
#(
   parameter int AVG_LOG2 = 2,
   parameter int SCAN_GAP = 50000,
   parameter int TIMEOUT  = 2000
) (
   input  logic                    Clk,
   input  logic                    Rst_n,
   input  logic                    Scan_en,
   input  logic [ADC_CHANNELS-1:0] Ch_mask,
   output logic                    En_convert,
   output logic [CH_W-1:0]         Adc_channel,
   input  logic                    Convert_done,
   input  logic                    Adc_state,
   input  logic [ADC_BITS-1:0]     Adc_result,
   output logic                    Result_valid,
   output logic [CH_W-1:0]         Result_ch,
   output logic [ADC_BITS-1:0]     Result_data,
   output logic                    Scan_done,
   input  logic [CH_W-1:0]         Rd_ch,
   output logic [ADC_BITS-1:0]     Rd_data,
   output logic [ADC_CHANNELS-1:0] Ch_valid,
   output logic                    Timeout_err
);

   localparam int ACC_W = ADC_BITS + AVG_LOG2;
   localparam int CNT_W = AVG_LOG2 + 1;
   localparam int TO_W  = $clog2(TIMEOUT + 2);
   localparam int GAP_W = $clog2(SCAN_GAP + 2);

   scan_state_t r_state;
   scan_state_t w_next;

   logic [ADC_CHANNELS-1:0] r_mask;
   logic [CH_W-1:0]         r_ptr;
   logic [ACC_W-1:0]        r_acc;
   logic [CNT_W-1:0]        r_cnt;
   logic [TO_W-1:0]         r_to;
   logic [GAP_W-1:0]        r_gap;
   logic [ADC_BITS-1:0]     r_file [ADC_CHANNELS];
   logic [ADC_CHANNELS-1:0] r_ch_valid;
   logic                    r_timeout_err;
   logic                    r_en_convert;
   logic                    r_result_valid;
   logic [CH_W-1:0]         r_result_ch;
   logic [ADC_BITS-1:0]     r_result_data;
   logic                    r_scan_done;

   logic [ADC_CHANNELS-1:0] w_srch_mask;
   logic                    w_from_start;
   logic [CH_W-1:0]         w_next_ch;
   logic                    w_found;
   logic [CNT_W-1:0]        w_cnt_inc;
   logic                    w_last;
   logic                    w_to_expired;
   logic                    w_gap_tc;
   logic [ACC_W-1:0]        w_acc_sum;
   logic [ADC_BITS-1:0]     w_avg_new;
   logic [ADC_BITS-1:0]     w_avg_store;
   logic                    w_en_d;
   logic                    w_rv_d;
   logic                    w_sd_d;

   // SCAN_INIT searches the live mask (it is being latched that cycle); NEXT uses the latched copy.
   assign w_from_start = (r_state == SCAN_INIT);
   assign w_srch_mask  = w_from_start ? Ch_mask : r_mask;

   adc_next_ch u_next_ch (
      .i_mask       (w_srch_mask),
      .i_ptr        (r_ptr),
      .i_from_start (w_from_start),
      .o_ch         (w_next_ch),
      .o_found      (w_found)
   );

   assign w_cnt_inc    = r_cnt + 1'b1;
   assign w_last       = (w_cnt_inc == CNT_W'(1 << AVG_LOG2));
   assign w_to_expired = (r_to == '0);
   assign w_gap_tc     = (r_gap <= GAP_W'(1));
   assign w_acc_sum    = r_acc + ACC_W'(Adc_result);
   assign w_avg_new    = ADC_BITS'(w_acc_sum >> AVG_LOG2);
   assign w_avg_store  = ADC_BITS'(r_acc >> AVG_LOG2);

   // State register.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state logic.
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE: begin
            if (Scan_en && (Ch_mask != 8'h00)) w_next = SCAN_INIT;
            else                              w_next = IDLE;
         end
         SCAN_INIT: begin
            if (w_found) w_next = ISSUE;
            else         w_next = IDLE;
         end
         ISSUE: begin
            if (!Adc_state) w_next = WAIT;
            else            w_next = ISSUE;
         end
         WAIT: begin
            if (Convert_done) begin
               if (w_last) w_next = STORE;
               else        w_next = ISSUE;
            end else if (w_to_expired) begin
               w_next = NEXT;
            end else begin
               w_next = WAIT;
            end
         end
         STORE: w_next = NEXT;
         NEXT: begin
            if (!Scan_en)           w_next = IDLE;
            else if (w_found)       w_next = ISSUE;
            else if (SCAN_GAP == 0) w_next = SCAN_INIT;
            else                    w_next = GAP;
         end
         GAP: begin
            if (!Scan_en)     w_next = IDLE;
            else if (w_gap_tc) w_next = SCAN_INIT;
            else              w_next = GAP;
         end
         default: w_next = IDLE;
      endcase
   end

   // Pulse decode; the pulses are registered so they appear the cycle after the decision.
   always_comb begin
      w_en_d = 1'b0;
      w_rv_d = 1'b0;
      w_sd_d = 1'b0;
      case (r_state)
         ISSUE:   w_en_d = !Adc_state;
         WAIT:    w_rv_d = Convert_done && w_last;
         NEXT:    w_sd_d = Scan_en && !w_found;
         default: w_en_d = 1'b0;
      endcase
   end

   // Output pulse registers.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         r_en_convert   <= 1'b0;
         r_result_valid <= 1'b0;
         r_result_ch    <= 3'd0;
         r_result_data  <= 12'd0;
         r_scan_done    <= 1'b0;
      end else begin
         r_en_convert   <= w_en_d;
         r_result_valid <= w_rv_d;
         r_scan_done    <= w_sd_d;
         if (w_rv_d) begin
            r_result_ch   <= r_ptr;
            r_result_data <= w_avg_new;
         end
      end
   end

   // Scan datapath: pointer, accumulator, timers, result file and status flags.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         r_mask        <= 8'h00;
         r_ptr         <= 3'd0;
         r_acc         <= '0;
         r_cnt         <= '0;
         r_to          <= '0;
         r_gap         <= '0;
         r_ch_valid    <= 8'h00;
         r_timeout_err <= 1'b0;
         for (int i = 0; i < ADC_CHANNELS; i++) r_file[i] <= 12'd0;
      end else begin
         case (r_state)
            SCAN_INIT: begin
               r_mask <= Ch_mask;
               r_ptr  <= w_next_ch;
               r_acc  <= '0;
               r_cnt  <= '0;
            end
            ISSUE: begin
               if (!Adc_state) r_to <= TO_W'(TIMEOUT - 1);
            end
            WAIT: begin
               if (Convert_done) begin
                  r_acc <= w_acc_sum;
                  r_cnt <= w_cnt_inc;
               end else if (w_to_expired) begin
                  r_timeout_err <= 1'b1;
               end else begin
                  r_to <= r_to - 1'b1;
               end
            end
            STORE: begin
               r_file[r_ptr]     <= w_avg_store;
               r_ch_valid[r_ptr] <= 1'b1;
            end
            NEXT: begin
               // Clearing here also drops a partial sum left behind by a timeout.
               if (w_found) r_ptr <= w_next_ch;
               r_acc <= '0;
               r_cnt <= '0;
               r_gap <= GAP_W'(SCAN_GAP);
            end
            GAP: r_gap <= r_gap - 1'b1;
            default: r_acc <= r_acc;
         endcase
      end
   end

   assign En_convert   = r_en_convert;
   assign Adc_channel  = r_ptr;
   assign Result_valid = r_result_valid;
   assign Result_ch    = r_result_ch;
   assign Result_data  = r_result_data;
   assign Scan_done    = r_scan_done;
   assign Ch_valid     = r_ch_valid;
   assign Timeout_err  = r_timeout_err;
   assign Rd_data      = r_file[Rd_ch];

endmodule

// File: tb/tb_adc_scan_ctrl.sv
// Directed scoreboard bench for adc_scan_ctrl with a behavioural ADC driver model.
module tb_adc_scan_ctrl;

   localparam int TO  = 2000;
   localparam int GAP = 20;

   logic        Clk = 1'b0;
   logic        Rst_n = 1'b0;
   logic        Scan_en = 1'b0;
   logic [7:0]  Ch_mask = 8'h00;
   logic        Convert_done = 1'b0;
   logic        Adc_state;
   logic [11:0] Adc_result = 12'd0;
   logic [2:0]  Rd_ch = 3'd0;
   logic        En_convert;
   logic [2:0]  Adc_channel;
   logic        Result_valid;
   logic [2:0]  Result_ch;
   logic [11:0] Result_data;
   logic        Scan_done;
   logic [11:0] Rd_data;
   logic [7:0]  Ch_valid;
   logic        Timeout_err;

   adc_scan_ctrl #(.AVG_LOG2(2), .SCAN_GAP(GAP), .TIMEOUT(TO)) dut (
      .Clk(Clk), .Rst_n(Rst_n), .Scan_en(Scan_en), .Ch_mask(Ch_mask),
      .En_convert(En_convert), .Adc_channel(Adc_channel), .Convert_done(Convert_done),
      .Adc_state(Adc_state), .Adc_result(Adc_result), .Result_valid(Result_valid),
      .Result_ch(Result_ch), .Result_data(Result_data), .Scan_done(Scan_done),
      .Rd_ch(Rd_ch), .Rd_data(Rd_data), .Ch_valid(Ch_valid), .Timeout_err(Timeout_err)
   );

   always #10 Clk = ~Clk;

   typedef struct { logic [2:0] ch; logic [11:0] data; } res_t;
   res_t       exp_res[$];
   logic [2:0] exp_ch[$];

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int mode = 0;
   int dead_ch = 8;
   bit force_busy = 1'b0;
   int samp_idx[8];
   int enc_n[8];
   int enc_cyc[8];
   int first_enc_cyc = -1;
   int to_rise_cyc = -1;
   int scan_done_cnt = 0;
   int drop_cyc = 0;
   int sd_before = 0;
   logic prev_busy = 1'b0;

   assign Adc_state = force_busy;

   always @(posedge Clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h)", nm, act, act, req, req);
      end
   endtask

   function automatic logic [11:0] value(input int m, input int ch, input int k);
      case (m)
         1: return (ch == 0) ? 12'(100 + k) : 12'd4000;
         2: return 12'hFFF;
         3: return 12'(7 + k);
         4: return (ch == 0) ? 12'(10 * (k + 1)) : ((k == 3) ? 12'd5 : 12'(k + 1));
         5: return 12'd200;
         6: return (ch == 1) ? 12'd50 : 12'(60 + k);
         default: return 12'd0;
      endcase
   endfunction

   // ADC driver model: answers each En_convert 5 cycles later unless the channel is dead.
   initial begin : driver
      int ch;
      forever begin
         @(posedge Clk); #1;
         Convert_done = 1'b0;
         if (Rst_n && En_convert) begin
            ch = int'(Adc_channel);
            if (ch != dead_ch) begin
               repeat (4) @(posedge Clk);
               #1;
               Adc_result   = value(mode, ch, samp_idx[ch]);
               samp_idx[ch] = samp_idx[ch] + 1;
               Convert_done = 1'b1;
               chk("ch_hold", 32'(Adc_channel), 32'(ch));
            end
         end
      end
   end

   // Monitor: pops the scoreboard whenever the DUT presents a pulse.
   initial begin : monitor
      res_t r;
      forever begin
         @(negedge Clk);
         if (Rst_n) begin
            if (En_convert) begin
               chk("enc_not_busy", 32'(prev_busy), 32'd0);
               enc_n[Adc_channel] = enc_n[Adc_channel] + 1;
               enc_cyc[Adc_channel] = cyc;
               if (first_enc_cyc < 0) first_enc_cyc = cyc;
               if (exp_ch.size() == 0) begin
                  total++; bad++;
                  $display("FAIL enc_unexpected: got ch %0d, required none", Adc_channel);
               end else begin
                  chk("enc_ch", 32'(Adc_channel), 32'(exp_ch.pop_front()));
               end
            end
            if (Result_valid) begin
               if (exp_res.size() == 0) begin
                  total++; bad++;
                  $display("FAIL res_unexpected: got ch %0d data %0d, required none", Result_ch, Result_data);
               end else begin
                  r = exp_res.pop_front();
                  chk("res_ch", 32'(Result_ch), 32'(r.ch));
                  chk("res_data", 32'(Result_data), 32'(r.data));
               end
            end
            if (Scan_done) begin
               scan_done_cnt++;
               chk("sd_after_stores", 32'(exp_res.size()), 32'd0);
            end
            if (Timeout_err && to_rise_cyc < 0) to_rise_cyc = cyc;
         end
         prev_busy = Adc_state;
      end
   end

   task automatic clear_model();
      for (int i = 0; i < 8; i++) begin
         samp_idx[i] = 0;
         enc_n[i] = 0;
         enc_cyc[i] = 0;
      end
      first_enc_cyc = -1;
      to_rise_cyc = -1;
   endtask

   task automatic do_reset();
      Scan_en = 1'b0;
      force_busy = 1'b0;
      Rst_n = 1'b0;
      repeat (2) @(posedge Clk);
      #1;
      Rst_n = 1'b1;
      clear_model();
   endtask

   task automatic push_ch(input logic [2:0] ch, input int n);
      for (int i = 0; i < n; i++) exp_ch.push_back(ch);
   endtask

   task automatic push_res(input logic [2:0] ch, input logic [11:0] d);
      res_t r;
      r.ch = ch;
      r.data = d;
      exp_res.push_back(r);
   endtask

   task automatic wait_done(input string nm, input int limit);
      int start;
      start = scan_done_cnt;
      for (int i = 0; i < limit; i++) begin
         @(posedge Clk);
         if (scan_done_cnt != start) break;
      end
      #1;
      Scan_en = 1'b0;
      chk(nm, 32'(scan_done_cnt - start), 32'd1);
   endtask

   task automatic settle();
      repeat (30) @(posedge Clk);
      #1;
      chk("expq_enc_empty", 32'(exp_ch.size()), 32'd0);
      chk("expq_res_empty", 32'(exp_res.size()), 32'd0);
   endtask

   task automatic rd(input string nm, input logic [2:0] ch, input logic [11:0] req);
      Rd_ch = ch;
      #1;
      chk(nm, 32'(Rd_data), 32'(req));
   endtask

   initial begin : watchdog
      #(40000 * 20);
      $display("FAIL watchdog: simulation exceeded its time budget");
      $fatal(1);
   end

   initial begin : stim
      clear_model();
      repeat (3) @(posedge Clk);
      #1;
      chk("rst_en_convert", 32'(En_convert), 32'd0);
      chk("rst_result_valid", 32'(Result_valid), 32'd0);
      chk("rst_scan_done", 32'(Scan_done), 32'd0);
      chk("rst_ch_valid", 32'(Ch_valid), 32'd0);
      chk("rst_timeout", 32'(Timeout_err), 32'd0);
      chk("rst_rd_data", 32'(Rd_data), 32'd0);
      Rst_n = 1'b1;

      // Mask 0 must not start a scan.
      Ch_mask = 8'h00; Scan_en = 1'b1;
      repeat (20) @(posedge Clk);
      #1; Scan_en = 1'b0;
      chk("mask0_no_scan", 32'(scan_done_cnt), 32'd0);

      // Two channels averaged, truncating (406/4 = 101).
      mode = 1;
      push_ch(3'd0, 4); push_ch(3'd2, 4);
      push_res(3'd0, 12'd101); push_res(3'd2, 12'd4000);
      Ch_mask = 8'h05; Scan_en = 1'b1;
      wait_done("t1_scan_done", 600);
      settle();
      rd("t1_rd_ch0", 3'd0, 12'd101);
      rd("t1_rd_ch2", 3'd2, 12'd4000);
      rd("t1_rd_ch1", 3'd1, 12'd0);
      chk("t1_ch_valid", 32'(Ch_valid), 32'h05);

      // Full-scale samples must average without overflow.
      do_reset();
      mode = 2;
      push_ch(3'd7, 4); push_res(3'd7, 12'hFFF);
      Ch_mask = 8'h80; Scan_en = 1'b1;
      wait_done("t2_scan_done", 600);
      settle();
      rd("t2_rd_ch7", 3'd7, 12'hFFF);
      chk("t2_ch_valid", 32'(Ch_valid), 32'h80);

      // Dead channel 3 times out; channel 4 still stores (34/4 = 8).
      do_reset();
      mode = 3; dead_ch = 3;
      push_ch(3'd3, 1); push_ch(3'd4, 4); push_res(3'd4, 12'd8);
      Ch_mask = 8'h18; Scan_en = 1'b1;
      wait_done("t3_scan_done", 3000);
      settle();
      dead_ch = 8;
      chk("t3_timeout_err", 32'(Timeout_err), 32'd1);
      chk("t3_timeout_latency", 32'(to_rise_cyc - enc_cyc[3]), 32'(TO));
      rd("t3_rd_ch3", 3'd3, 12'd0);
      rd("t3_rd_ch4", 3'd4, 12'd8);
      chk("t3_ch_valid", 32'(Ch_valid), 32'h10);

      // Scan_en drops during channel 1's second sample: ch1 finishes, no Scan_done (11/4 = 2).
      do_reset();
      chk("t4_timeout_cleared", 32'(Timeout_err), 32'd0);
      mode = 4;
      push_ch(3'd0, 4); push_ch(3'd1, 4);
      push_res(3'd0, 12'd25); push_res(3'd1, 12'd2);
      sd_before = scan_done_cnt;
      Ch_mask = 8'h03; Scan_en = 1'b1;
      for (int i = 0; i < 500; i++) begin
         @(posedge Clk);
         if (enc_n[1] >= 2) break;
      end
      #1; Scan_en = 1'b0;
      chk("t4_reached_ch1_s2", 32'(enc_n[1]), 32'd2);
      repeat (100) @(posedge Clk);
      settle();
      chk("t4_no_scan_done", 32'(scan_done_cnt - sd_before), 32'd0);
      chk("t4_ch1_enc_count", 32'(enc_n[1]), 32'd4);
      rd("t4_rd_ch1", 3'd1, 12'd2);
      chk("t4_ch_valid", 32'(Ch_valid), 32'h03);

      // Driver busy for 300 cycles on ISSUE entry.
      do_reset();
      mode = 5; force_busy = 1'b1;
      push_ch(3'd0, 4); push_res(3'd0, 12'd200);
      Ch_mask = 8'h01; Scan_en = 1'b1;
      repeat (300) @(posedge Clk);
      #1;
      chk("t5_no_enc_while_busy", 32'(first_enc_cyc), 32'hFFFF_FFFF);
      force_busy = 1'b0;
      drop_cyc = cyc;
      wait_done("t5_scan_done", 600);
      chk("t5_issue_latency", 32'(first_enc_cyc - drop_cyc), 32'd1);
      settle();

      // Asynchronous reset in the middle of a WAIT, then restart from the lowest channel.
      mode = 6; dead_ch = 1;
      push_ch(3'd1, 1);
      Ch_mask = 8'h06; Scan_en = 1'b1;
      for (int i = 0; i < 200; i++) begin
         @(posedge Clk);
         if (enc_n[1] >= 1) break;
      end
      repeat (10) @(posedge Clk);
      #1;
      chk("t6_pre_ch_valid", 32'(Ch_valid), 32'h01);
      #4; Rst_n = 1'b0; #1;
      chk("t6_async_ch_valid", 32'(Ch_valid), 32'd0);
      chk("t6_async_adc_channel", 32'(Adc_channel), 32'd0);
      chk("t6_async_en_convert", 32'(En_convert), 32'd0);
      chk("t6_async_result_valid", 32'(Result_valid), 32'd0);
      rd("t6_async_rd_ch0", 3'd0, 12'd0);
      repeat (2) @(posedge Clk);
      #1;
      dead_ch = 8;
      clear_model();
      push_ch(3'd1, 4); push_ch(3'd2, 4);
      push_res(3'd1, 12'd50); push_res(3'd2, 12'd61);
      Rst_n = 1'b1;
      wait_done("t6_scan_done", 600);
      settle();
      rd("t6_rd_ch2", 3'd2, 12'd61);
      chk("t6_ch_valid", 32'(Ch_valid), 32'h06);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/adc_scan_ctrl.md
Name: adc_scan_ctrl

Overview:
- Upstream sequencer for the adc_18s022 SPI ADC driver.
- Scans the enabled channels of an 8-channel ADC128S022 round-robin, issuing one-cycle En_convert pulses and consuming Convert_done / Adc_result.
- Averages 2^AVG_LOG2 samples per channel and stores the averages in an 8-entry result file.
- Downstream logic reads the file at random through a combinational read port and sees per-channel update pulses.

Parameters:
- AVG_LOG2, 2: log2 of samples averaged per channel. Legal range 0..4.
- SCAN_GAP, 50000: idle Clk cycles between the end of one scan and the start of the next (1 ms at 50 MHz). Legal values are 0 or greater.
- TIMEOUT, 2000: Clk cycles to wait for Convert_done before aborting a conversion.

Ports:
- Clk  in  1  system clock, 50 MHz
- Rst_n  in  1  asynchronous active-low reset
- Scan_en  in  1  level; continuous scanning while high
- Ch_mask  in  8  channel enable mask, bit n = channel n; sampled at scan start
- En_convert  out  1  one-cycle pulse to the ADC driver
- Adc_channel  out  3  channel address to the ADC driver
- Convert_done  in  1  one-cycle pulse from the driver; Adc_result valid in the same cycle
- Adc_state  in  1  driver busy flag
- Adc_result  in  12  driver conversion result
- Result_valid  out  1  one-cycle pulse when a channel average is written
- Result_ch  out  3  channel written, valid with Result_valid
- Result_data  out  12  average written, valid with Result_valid
- Scan_done  out  1  one-cycle pulse at the end of each full scan
- Rd_ch  in  3  read address
- Rd_data  out  12  combinational read of result file[Rd_ch]
- Ch_valid  out  8  bit n set once channel n has been written since reset
- Timeout_err  out  1  sticky flag, set on any conversion timeout

Behaviour:
- Reset (async, Rst_n low):
  - All outputs to 0; result file to 0; Ch_valid = 0; FSM to IDLE.
  - Reset mid-conversion abandons the scan with no further pulses.
- FSM states and transitions:
  - IDLE:
    - Move to SCAN_INIT when Scan_en = 1 and Ch_mask != 0.
    - Mask = 0 stays in IDLE, with no pulses.
  - SCAN_INIT:
    - Latch Ch_mask into mask_q.
    - Channel pointer = lowest set bit.
    - Clear accumulator and sample counter.
    - Go to ISSUE.
  - ISSUE:
    - Wait until Adc_state = 0.
    - Then drive En_convert = 1 for exactly one cycle, with Adc_channel = pointer.
    - Adc_channel is held stable from this cycle until Convert_done.
    - Load the timeout counter; go to WAIT.
  - WAIT:
    - On Convert_done: acc += Adc_result. acc width is 12+AVG_LOG2 bits; no overflow is possible.
    - Then increment the sample counter.
      - If counter = 2^AVG_LOG2: go to STORE.
      - Otherwise: go back to ISSUE.
    - If the timeout counter expires first:
      - Set Timeout_err.
      - Discard the channel's partial accumulation; the result file entry is unchanged.
      - Go to NEXT.
    - A Convert_done outside WAIT is ignored.
  - STORE:
    - file[ptr] = acc >> AVG_LOG2 (truncating).
    - Set Ch_valid[ptr].
    - Pulse Result_valid for one cycle with Result_ch / Result_data.
    - Go to NEXT.
  - NEXT:
    - Advance the pointer to the next higher set bit of mask_q, clear acc and the counter, then go to ISSUE.
    - If no higher set bit exists: pulse Scan_done.
      - If SCAN_GAP = 0 and Scan_en = 1, go straight to SCAN_INIT.
      - Otherwise go to GAP.
  - GAP:
    - Count SCAN_GAP cycles.
    - At terminal count: go to SCAN_INIT if Scan_en = 1, else IDLE.
    - A Scan_en fall during GAP goes to IDLE immediately.
- Scan_en deassert mid-scan:
  - The in-flight channel completes (STORE or timeout).
  - NEXT then goes to IDLE without Scan_done.
- A Ch_mask change mid-scan takes effect at the next SCAN_INIT.
- Simultaneous STORE write and Rd_ch read of the same channel: Rd_data shows the old value that cycle and the new value the next cycle.
- Timeout_err clears only on reset.
- Latency: at most 1 cycle from FSM entry into ISSUE (with Adc_state low) to En_convert; exactly 1 cycle from the final Convert_done to Result_valid.

Decomposition:
- Shared package adc_pkg:
  - FSM state encoding localparams: IDLE, SCAN_INIT, ISSUE, WAIT, STORE, NEXT, GAP.
  - ADC_BITS = 12, ADC_CHANNELS = 8.
- One natural sub-module, adc_next_ch: combinational priority encoder that returns the next set mask bit above a given pointer, plus a found flag. Used in both SCAN_INIT and NEXT.
- The result file stays inline as an 8x12 register array.

Test Plan:
- Mask 8'h05, AVG_LOG2 = 2, driver model returns 100, 101, 102, 103 on channel 0 and 4000 (x4) on channel 2:
  - Result_valid ch0 = 101, then ch2 = 4000.
  - Scan_done after the ch2 store.
  - Adc_channel sequence: 0, 0, 0, 0, 2, 2, 2, 2.
- Mask 8'h80, all samples 12'hFFF: average 12'hFFF exactly, Ch_valid = 8'h80.
- Driver model never asserts Convert_done on channel 3, mask 8'h18:
  - Timeout_err rises 2000 cycles after En_convert.
  - Channel 3 entry stays 0 and its Ch_valid bit stays clear.
  - Channel 4 then stores normally.
- Scan_en dropped during the second sample of channel 1, mask 8'h03:
  - Channel 1 still stores.
  - No En_convert follows; FSM reaches IDLE and Scan_done does not pulse.
- Adc_state held high 300 cycles on entry to ISSUE: En_convert fires 1 cycle after Adc_state falls, never while it is high.
- Rst_n asserted mid-WAIT:
  - All outputs and Ch_valid go to 0 asynchronously.
  - After release with Scan_en = 1, the scan restarts from the lowest set bit.
